// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of one single-port RAM, with a bounded ownership lock.
// Latency: grant and memory mux are combinational; read data returns one cycle after the grant.
// Backpressure: the losing requester sees mX_waitrequest=1 until it is granted.
// Ports: clk/reset_n (async, active-low); m0_*/m1_* Avalon-MM slave-side master ports
//   (address, byteenable, read, write, writedata, lock in; waitrequest, readdata, readdatavalid out);
//   mem_* drives the RAM (address, byteenable, chipselect, write, writedata out; readdata in).
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata
);

  typedef enum logic {ARB, LOCKED} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  state_t     state, state_nxt;
  logic       lock_owner, lock_owner_nxt;
  logic [7:0] lock_cnt, lock_cnt_nxt;
  logic       last_grant, last_grant_nxt;
  logic       rd_pending, rd_owner;

  logic req0, req1, grant0, grant1, any_grant;
  logic g_read, g_write, g_lock, owner_done;
  logic [7:0] cnt_inc;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grants are suppressed while reset is held so the RAM never sees a stray access.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (state == LOCKED) begin
        grant0 = req0 & ~lock_owner;
        grant1 = req1 &  lock_owner;
      end else if (req0 && req1) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign any_grant = grant0 | grant1;
  assign g_read    = grant1 ? m1_read  : m0_read;
  assign g_write   = grant1 ? m1_write : m0_write;
  assign g_lock    = grant1 ? m1_lock  : m0_lock;

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end else if (grant0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end
  end
  assign mem_chipselect = any_grant;

  // lock_cnt counts cycles of ownership including the granting cycle in ARB,
  // so cnt_inc is the ownership length once the current cycle completes.
  assign cnt_inc    = lock_cnt + 8'd1;
  assign owner_done = lock_owner ? (grant1 & ~m1_lock) : (grant0 & ~m0_lock);

  always_comb begin
    state_nxt      = state;
    lock_owner_nxt = lock_owner;
    lock_cnt_nxt   = lock_cnt;
    last_grant_nxt = last_grant;
    if (any_grant) last_grant_nxt = grant1;
    case (state)
      ARB: begin
        // With MAX_LOCK of 1 the granting cycle already exhausts the lock.
        if (any_grant && g_lock && (MAX_CNT > 8'd1)) begin
          state_nxt      = LOCKED;
          lock_owner_nxt = grant1;
          lock_cnt_nxt   = 8'd1;
        end
      end
      LOCKED: begin
        lock_cnt_nxt = cnt_inc;
        if (owner_done || (cnt_inc >= MAX_CNT)) begin
          state_nxt      = ARB;
          lock_cnt_nxt   = 8'd0;
          last_grant_nxt = lock_owner;  // the other master wins the next tie
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB;
      lock_owner <= 1'b0;
      lock_cnt   <= 8'd0;
      last_grant <= 1'b1;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      state      <= state_nxt;
      lock_owner <= lock_owner_nxt;
      lock_cnt   <= lock_cnt_nxt;
      last_grant <= last_grant_nxt;
      // A simultaneous read+write is treated as a write only.
      rd_pending <= any_grant & g_read & ~g_write;
      rd_owner   <= grant1;
    end
  end

  assign m0_readdatavalid = rd_pending & ~rd_owner;
  assign m1_readdatavalid = rd_pending &  rd_owner;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: RAM device model, ownership/round-robin reference model,
// per-cycle comparison, directed scenarios with literal expectations, then random traffic.
module tb_onchip_mem_arbiter;
  localparam int AW = 18;
  localparam int ML = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [3:0]    m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0]   m0_writedata, m1_writedata, mem_writedata, mem_readdata;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0]   m0_readdata, m1_readdata;
  logic          mem_chipselect, mem_write;

  onchip_mem_arbiter #(.ADDR_W(AW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(int a);
    return 32'hA500_0000 ^ 32'(a);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- RAM device: registered address, unregistered output ----------------
  logic [31:0] ram [int];
  logic [31:0] ram_q = 32'h0;
  assign mem_readdata = ram_q;

  function automatic logic [31:0] ram_rd(int a);
    return ram.exists(a) ? ram[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    int a;
    a = int'(mem_address);
    if (mem_chipselect === 1'b1) begin
      if (mem_write) ram[a] = merge(ram_rd(a), mem_writedata, mem_byteenable);
      else ram_q <= ram_rd(a);
    end
  end

  // ---------------- Reference model ----------------
  bit          mdl_locked = 0;
  int          mdl_owner = 0, mdl_held = 0, mdl_last = 1;
  bit          mdl_pend = 0;
  int          mdl_pend_owner = 0;
  logic [31:0] mdl_pend_data = 0;
  logic [31:0] mdl_mem [int];

  function automatic logic [31:0] mdl_rd(int a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
  endfunction

  always @(negedge clk) begin
    bit r[2], rd[2], wr[2], lk[2];
    logic [AW-1:0] ad[2];
    logic [3:0] be[2];
    logic [31:0] wd[2];
    int g;
    rd[0] = m0_read; wr[0] = m0_write; lk[0] = m0_lock; ad[0] = m0_address; be[0] = m0_byteenable; wd[0] = m0_writedata;
    rd[1] = m1_read; wr[1] = m1_write; lk[1] = m1_lock; ad[1] = m1_address; be[1] = m1_byteenable; wd[1] = m1_writedata;
    r[0] = rd[0] | wr[0];
    r[1] = rd[1] | wr[1];
    g = -1;
    if (!reset_n) begin
      mdl_locked = 0; mdl_held = 0; mdl_last = 1; mdl_pend = 0;
    end else if (mdl_locked) begin
      if (r[mdl_owner]) g = mdl_owner;
    end else if (r[0] && r[1]) begin
      g = (mdl_last == 1) ? 0 : 1;
    end else if (r[0]) g = 0;
    else if (r[1]) g = 1;

    chk("m0_waitrequest", 64'(m0_waitrequest), 64'(r[0] && g != 0));
    chk("m1_waitrequest", 64'(m1_waitrequest), 64'(r[1] && g != 1));
    chk("mem_chipselect", 64'(mem_chipselect), 64'(g >= 0));
    chk("mem_write", 64'(mem_write), 64'(g >= 0 && wr[g]));
    chk("mem_address", 64'(mem_address), (g >= 0) ? 64'(ad[g]) : 64'h0);
    chk("mem_byteenable", 64'(mem_byteenable), (g >= 0) ? 64'(be[g]) : 64'h0);
    chk("mem_writedata", 64'(mem_writedata), (g >= 0) ? 64'(wd[g]) : 64'h0);
    chk("m0_readdatavalid", 64'(m0_readdatavalid), 64'(mdl_pend && mdl_pend_owner == 0));
    chk("m1_readdatavalid", 64'(m1_readdatavalid), 64'(mdl_pend && mdl_pend_owner == 1));
    if (mdl_pend) begin
      chk("m0_readdata", 64'(m0_readdata), 64'(mdl_pend_data));
      chk("m1_readdata", 64'(m1_readdata), 64'(mdl_pend_data));
    end

    if (reset_n) begin
      mdl_pend = 0;
      if (g >= 0) begin
        if (wr[g]) mdl_mem[int'(ad[g])] = merge(mdl_rd(int'(ad[g])), wd[g], be[g]);
        else if (rd[g]) begin
          mdl_pend = 1; mdl_pend_owner = g; mdl_pend_data = mdl_rd(int'(ad[g]));
        end
        mdl_last = g;
      end
      if (!mdl_locked) begin
        if (g >= 0 && lk[g]) begin
          mdl_locked = 1; mdl_owner = g; mdl_held = 1;
          if (mdl_held >= ML) mdl_locked = 0;
        end
      end else begin
        mdl_held++;
        if ((g == mdl_owner && !lk[mdl_owner]) || mdl_held >= ML) begin
          mdl_locked = 0;
          mdl_last = mdl_owner;
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic idle();
    m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int run0;
    bit seen1;
    logic [3:0] op;
    ram[16] = 32'hDEADBEEF;
    mdl_mem[16] = 32'hDEADBEEF;
    idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_m0_valid", 64'(m0_readdatavalid), 64'h0);
    chk("reset_m1_valid", 64'(m1_readdatavalid), 64'h0);
    chk("reset_chipselect", 64'(mem_chipselect), 64'h0);
    chk("reset_mem_write", 64'(mem_write), 64'h0);
    step();
    reset_n = 1;

    // Contention: both masters write continuously; m0 wins first tie.
    m0_write = 1; m0_address = 18'h20; m0_writedata = 32'h1111_1111; m0_byteenable = 4'hF;
    m1_write = 1; m1_address = 18'h21; m1_writedata = 32'h2222_2222; m1_byteenable = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("contention_grant", 64'({~m0_waitrequest, ~m1_waitrequest}), (i % 2 == 0) ? 64'h2 : 64'h1);
      step();
    end
    idle();

    // Single read of preloaded word.
    m0_read = 1; m0_address = 18'h10;
    @(negedge clk);
    chk("single_read_wait", 64'(m0_waitrequest), 64'h0);
    step(); idle();
    @(negedge clk);
    chk("single_read_valid", 64'(m0_readdatavalid), 64'h1);
    chk("single_read_data", 64'(m0_readdata), 64'hDEADBEEF);
    chk("single_read_other", 64'(m1_readdatavalid), 64'h0);
    step();

    // Read back the half-written word from m1.
    m1_read = 1; m1_address = 18'h21;
    step(); idle();
    @(negedge clk);
    chk("be_readback_valid", 64'(m1_readdatavalid), 64'h1);
    chk("be_readback_data", 64'(m1_readdata), 64'hA500_2222);
    step();

    // Locked read-modify-write by m1 while m0 requests continuously.
    m0_read = 1; m0_address = 18'h5;
    step();
    m1_read = 1; m1_lock = 1; m1_address = 18'h100;
    @(negedge clk);
    chk("rmw_rd_m0_wait", 64'(m0_waitrequest), 64'h1);
    chk("rmw_rd_m1_wait", 64'(m1_waitrequest), 64'h0);
    step();
    m1_read = 0; m1_write = 1; m1_lock = 0; m1_writedata = 32'h0000_5A5A;
    @(negedge clk);
    chk("rmw_wr_m0_wait", 64'(m0_waitrequest), 64'h1);
    chk("rmw_wr_m1_wait", 64'(m1_waitrequest), 64'h0);
    step();
    m1_write = 0;
    @(negedge clk);
    chk("rmw_after_m0_wait", 64'(m0_waitrequest), 64'h0);
    step(); idle(); step();

    // Lock timeout: m0 holds lock continuously, m1 joins from the second cycle.
    m0_write = 1; m0_lock = 1; m0_address = 18'h7; m0_writedata = 32'h7777_7777;
    run0 = 0; seen1 = 0;
    for (int i = 0; i < 14 && !seen1; i++) begin
      @(negedge clk);
      if (!m1_waitrequest && m1_write) seen1 = 1;
      else if (!m0_waitrequest) run0++;
      step();
      m1_write = 1; m1_address = 18'h8; m1_writedata = 32'h8888_8888;
    end
    idle();
    chk("lock_timeout_run", 64'(run0), 64'd8);
    chk("lock_timeout_m1_granted", 64'(seen1), 64'h1);
    step();

    // Reset in the data cycle of a granted read.
    m0_read = 1; m0_address = 18'h10;
    @(negedge clk);
    chk("rst_read_granted", 64'(m0_waitrequest), 64'h0);
    step(); idle();
    reset_n = 0;
    @(negedge clk);
    chk("rst_m0_valid", 64'(m0_readdatavalid), 64'h0);
    chk("rst_m1_valid", 64'(m1_readdatavalid), 64'h0);
    step();
    reset_n = 1;
    @(negedge clk);
    chk("rst_after_m0_valid", 64'(m0_readdatavalid), 64'h0);
    step();
    m0_write = 1; m1_write = 1; m0_address = 18'h3; m1_address = 18'h4;
    @(negedge clk);
    chk("rst_tie_m0_wait", 64'(m0_waitrequest), 64'h0);
    chk("rst_tie_m1_wait", 64'(m1_waitrequest), 64'h1);
    step(); idle();

    // Read and write together on m1: write wins, no read data.
    m1_read = 1; m1_write = 1; m1_address = 18'h30; m1_writedata = 32'h3333_3333;
    @(negedge clk);
    chk("rw_mem_write", 64'(mem_write), 64'h1);
    step(); idle();
    @(negedge clk);
    chk("rw_no_valid", 64'(m1_readdatavalid), 64'h0);
    step();

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n = (i == 1500) ? 1'b0 : 1'b1;
      op = 4'($urandom_range(0, 4));
      m0_read = (op == 1 || op == 3 || op == 4); m0_write = (op == 2 || op == 3);
      m0_lock = ($urandom_range(0, 3) == 0);
      m0_address = 18'($urandom_range(0, 9)); m0_byteenable = 4'($urandom);
      m0_writedata = $urandom;
      op = 4'($urandom_range(0, 4));
      m1_read = (op == 1 || op == 3 || op == 4); m1_write = (op == 2 || op == 3);
      m1_lock = ($urandom_range(0, 3) == 0);
      m1_address = 18'($urandom_range(0, 9)); m1_byteenable = 4'($urandom);
      m1_writedata = $urandom;
      step();
    end
    reset_n = 1;
    idle();
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
